// File: rtl/gr_file_sb_pkg.sv
// ============================================================================
// Module   : gr_file_sb_pkg
// Purpose  : Shared defaults and destination-slot layout for gr_file_sb.
// Revision : 1.0
// ============================================================================
`default_nettype none

package gr_file_sb_pkg;

  localparam int c_DEF_DATA_W  = 16;
  localparam int c_DEF_NREG    = 8;
  localparam int c_DEF_PIPE    = 3;
  localparam int c_DEF_FLUSH_N = 2;
  localparam int c_NPORTS      = 3;

  typedef enum logic [1:0] {
    PORT_A = 2'd0,
    PORT_B = 2'd1,
    PORT_C = 2'd2
  } rd_port_e;

  // A slot is {valid, addr}: the valid flag sits directly above the address field.
  function automatic int slot_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int slot_valid_bit(input int aw);
    return aw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gr_dest_pipe.sv
// ============================================================================
// Module   : gr_dest_pipe
// Purpose  : In-flight destination shift register with flush, RAW hazard
//            detection and WB consistency checking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gr_dest_pipe
  import gr_file_sb_pkg::*;
#(
  parameter int AW      = 3,
  parameter int PIPE    = c_DEF_PIPE,
  parameter int FLUSH_N = c_DEF_FLUSH_N,
  parameter int ZERO_R0 = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          flush,
  input  logic          id_issue,
  input  logic          id_we,
  input  logic [AW-1:0] id_waddr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] rd_addr_c,
  input  logic          rd_use_a,
  input  logic          rd_use_b,
  input  logic          rd_use_c,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  output logic          stall,
  output logic          sb_err
);

  localparam int c_VB = slot_valid_bit(AW);
  localparam int c_SW = slot_w(AW);

  logic [c_SW-1:0]     r_slot [PIPE];
  logic                r_sb_err;
  logic [AW-1:0]       w_raddr [c_NPORTS];
  logic [c_NPORTS-1:0] w_ruse;
  logic [c_SW-1:0]     w_top;
  logic                w_hit;
  logic                w_zero_dest;
  logic                w_new_valid;
  logic                w_wb_mismatch;

  assign w_raddr[PORT_A] = rd_addr_a;
  assign w_raddr[PORT_B] = rd_addr_b;
  assign w_raddr[PORT_C] = rd_addr_c;
  assign w_ruse          = {rd_use_c, rd_use_b, rd_use_a};

  // The WB slot is excluded: its value is already forwarded by the bypass.
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < PIPE - 1; k++) begin
      for (int x = 0; x < c_NPORTS; x++) begin
        if (w_ruse[x] && r_slot[k][c_VB] && (r_slot[k][AW-1:0] == w_raddr[x]))
          w_hit = 1'b1;
      end
    end
  end

  assign stall         = run & w_hit;
  assign w_zero_dest   = (ZERO_R0 != 0) && (id_waddr == '0);
  assign w_new_valid   = id_issue & id_we & ~w_hit & ~flush & ~w_zero_dest;
  assign w_top         = r_slot[PIPE-1];
  assign w_wb_mismatch = (wb_we != w_top[c_VB]) ||
                         (wb_we && w_top[c_VB] && (wb_addr != w_top[AW-1:0]));

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < PIPE; k++) r_slot[k] <= '0;
      r_sb_err <= 1'b0;
    end else if (run) begin
      r_slot[0] <= {w_new_valid, id_waddr};
      for (int k = 1; k < PIPE; k++) begin
        if (flush && (k < FLUSH_N)) r_slot[k] <= '0;
        else                        r_slot[k] <= r_slot[k-1];
      end
      if (w_wb_mismatch) r_sb_err <= 1'b1;
    end
  end

  assign sb_err = r_sb_err;

endmodule

`default_nettype wire

// File: rtl/gr_file_sb.sv
// ============================================================================
// Module   : gr_file_sb
// Purpose  : General-register file with three bypassed read ports, one WB
//            write port and an in-flight destination scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gr_file_sb
  import gr_file_sb_pkg::*;
#(
  parameter int DATA_W  = c_DEF_DATA_W,
  parameter int NREG    = c_DEF_NREG,
  parameter int AW      = $clog2(NREG),
  parameter int PIPE    = c_DEF_PIPE,
  parameter int FLUSH_N = c_DEF_FLUSH_N,
  parameter int ZERO_R0 = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [AW-1:0]          rd_addr_a,
  input  logic [AW-1:0]          rd_addr_b,
  input  logic [AW-1:0]          rd_addr_c,
  input  logic                   rd_use_a,
  input  logic                   rd_use_b,
  input  logic                   rd_use_c,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic [DATA_W-1:0]      rd_data_c,
  input  logic                   id_issue,
  input  logic                   id_we,
  input  logic [AW-1:0]          id_waddr,
  input  logic                   flush,
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   stall,
  output logic [NREG*DATA_W-1:0] gr_flat,
  output logic                   sb_err
);

  localparam bit c_ZERO = (ZERO_R0 != 0);

  logic [DATA_W-1:0] r_gr    [NREG];
  logic [AW-1:0]     w_raddr [c_NPORTS];
  logic [DATA_W-1:0] w_rdata [c_NPORTS];
  logic              w_wb_eff;
  logic              w_wr;

  // A WB to a hardwired-zero r0 is not a real write, so it also never
  // counts against the scoreboard.
  assign w_wb_eff = wb_we && !(c_ZERO && (wb_addr == '0));
  assign w_wr     = run && w_wb_eff;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_gr[i] <= '0;
    end else if (w_wr) begin
      r_gr[wb_addr] <= wb_data;
    end
  end

  assign w_raddr[PORT_A] = rd_addr_a;
  assign w_raddr[PORT_B] = rd_addr_b;
  assign w_raddr[PORT_C] = rd_addr_c;

  always_comb begin
    w_rdata = '{default: '0};
    for (int x = 0; x < c_NPORTS; x++) begin
      if (c_ZERO && (w_raddr[x] == '0))
        w_rdata[x] = '0;
      else if (w_wr && (wb_addr == w_raddr[x]))
        w_rdata[x] = wb_data;
      else
        w_rdata[x] = r_gr[w_raddr[x]];
    end
  end

  assign rd_data_a = w_rdata[PORT_A];
  assign rd_data_b = w_rdata[PORT_B];
  assign rd_data_c = w_rdata[PORT_C];

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign gr_flat[i*DATA_W +: DATA_W] = r_gr[i];
  end

  gr_dest_pipe #(
    .AW      (AW),
    .PIPE    (PIPE),
    .FLUSH_N (FLUSH_N),
    .ZERO_R0 (ZERO_R0)
  ) u_dest_pipe (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .flush     (flush),
    .id_issue  (id_issue),
    .id_we     (id_we),
    .id_waddr  (id_waddr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_addr_c (rd_addr_c),
    .rd_use_a  (rd_use_a),
    .rd_use_b  (rd_use_b),
    .rd_use_c  (rd_use_c),
    .wb_we     (w_wb_eff),
    .wb_addr   (wb_addr),
    .stall     (stall),
    .sb_err    (sb_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_gr_file_sb.sv
// ============================================================================
// Module   : tb_gr_file_sb
// Purpose  : Directed bench for gr_file_sb (plain and hardwired-r0 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gr_file_sb;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              run   = 1'b0;
  logic [AW-1:0]     rd_addr_a, rd_addr_b, rd_addr_c;
  logic              rd_use_a, rd_use_b, rd_use_c;
  logic              id_issue, id_we, flush, wb_we;
  logic [AW-1:0]     id_waddr, wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic [DATA_W-1:0]      d0_rd_a, d0_rd_b, d0_rd_c, d1_rd_a, d1_rd_b, d1_rd_c;
  logic                   d0_stall, d1_stall, d0_err, d1_err;
  logic [NREG*DATA_W-1:0] d0_flat, d1_flat;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  gr_file_sb #(.ZERO_R0(0)) dut (
    .clock(clock), .reset(reset), .run(run),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_use_a(rd_use_a), .rd_use_b(rd_use_b), .rd_use_c(rd_use_c),
    .rd_data_a(d0_rd_a), .rd_data_b(d0_rd_b), .rd_data_c(d0_rd_c),
    .id_issue(id_issue), .id_we(id_we), .id_waddr(id_waddr), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(d0_stall), .gr_flat(d0_flat), .sb_err(d0_err)
  );

  gr_file_sb #(.ZERO_R0(1)) dut_z (
    .clock(clock), .reset(reset), .run(run),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_addr_c(rd_addr_c),
    .rd_use_a(rd_use_a), .rd_use_b(rd_use_b), .rd_use_c(rd_use_c),
    .rd_data_a(d1_rd_a), .rd_data_b(d1_rd_b), .rd_data_c(d1_rd_c),
    .id_issue(id_issue), .id_we(id_we), .id_waddr(id_waddr), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(d1_stall), .gr_flat(d1_flat), .sb_err(d1_err)
  );

  task automatic idle_inputs();
    rd_addr_a = '0; rd_addr_b = '0; rd_addr_c = '0;
    rd_use_a  = 1'b0; rd_use_b = 1'b0; rd_use_c = 1'b0;
    id_issue  = 1'b0; id_we = 1'b0; id_waddr = '0; flush = 1'b0;
    wb_we     = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string t, input logic [127:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [127:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    run   = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset dominates a pending WB write
    idle_inputs();
    reset = 1'b0; run = 1'b1;
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'hFFFF;
    push("rst_flat", 128'h0); push("rst_flat_z", 128'h0);
    push("rst_stall", 128'h0); push("rst_err", 128'h0);
    tick(); tick();
    pop_chk(d0_flat); pop_chk(d1_flat); pop_chk(d0_stall); pop_chk(d0_err);
    idle_inputs();
    reset = 1'b1;

    // Bypass: r5 travels to the WB slot, then is written
    id_issue = 1'b1; id_we = 1'b1; id_waddr = 3'd5;
    tick();
    idle_inputs();
    tick(); tick();
    wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234; rd_addr_a = 3'd5; rd_use_a = 1'b1;
    push("byp_data", 128'h1234); push("byp_stall", 128'h0);
    @(negedge clock);
    pop_chk(d0_rd_a); pop_chk(d0_stall);
    push("byp_reg", 128'h1234); push("byp_err", 128'h0);
    tick();
    pop_chk(d0_flat[5*DATA_W +: DATA_W]); pop_chk(d0_err);
    wb_we = 1'b0;
    push("arr_read", 128'h1234);
    @(negedge clock);
    pop_chk(d0_rd_a);

    // RAW stall on r2 with a held r7 issue behind it
    do_reset();
    id_issue = 1'b1; id_we = 1'b1; id_waddr = 3'd2;
    tick();
    id_waddr = 3'd7; rd_addr_b = 3'd2; rd_use_b = 1'b1;
    push("raw_c1_stall", 128'h1);
    @(negedge clock); pop_chk(d0_stall);
    tick();
    push("raw_c2_stall", 128'h1);
    @(negedge clock); pop_chk(d0_stall);
    tick();
    wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'h00AB;
    push("raw_c3_stall", 128'h0); push("raw_c3_byp", 128'h00AB);
    @(negedge clock); pop_chk(d0_stall); pop_chk(d0_rd_b);
    tick();
    idle_inputs();
    rd_addr_a = 3'd7; rd_use_a = 1'b1;
    push("raw_r7_pending", 128'h1);
    @(negedge clock); pop_chk(d0_stall);
    push("raw_bubble1", 128'h0);
    tick(); pop_chk(d0_err);
    idle_inputs();
    push("raw_bubble2", 128'h0);
    tick(); pop_chk(d0_err);
    wb_we = 1'b1; wb_addr = 3'd7; wb_data = 16'h0077;
    push("raw_wb7_err", 128'h0); push("raw_r2", 128'h00AB); push("raw_r7", 128'h0077);
    tick();
    pop_chk(d0_err); pop_chk(d0_flat[2*DATA_W +: DATA_W]); pop_chk(d0_flat[7*DATA_W +: DATA_W]);
    idle_inputs();

    // Flush squashes r4 and the issuing r6; r1 survives to WB
    do_reset();
    id_issue = 1'b1; id_we = 1'b1; id_waddr = 3'd1;
    tick();
    id_waddr = 3'd4;
    tick();
    id_waddr = 3'd6; flush = 1'b1; rd_addr_a = 3'd4; rd_use_a = 1'b1;
    push("fl_pre_stall", 128'h1);
    @(negedge clock); pop_chk(d0_stall);
    tick();
    idle_inputs();
    wb_we = 1'b1; wb_addr = 3'd1; wb_data = 16'h0101;
    rd_use_a = 1'b1; rd_addr_a = 3'd4;
    push("fl_r4_gone", 128'h0);
    @(negedge clock); pop_chk(d0_stall);
    rd_addr_a = 3'd6;
    push("fl_r6_gone", 128'h0);
    #1; pop_chk(d0_stall);
    rd_addr_a = 3'd1;
    push("fl_r1_wbslot", 128'h0); push("fl_r1_byp", 128'h0101);
    #1; pop_chk(d0_stall); pop_chk(d0_rd_a);
    push("fl_wb_err", 128'h0);
    tick(); pop_chk(d0_err);
    idle_inputs();
    tick();
    push("fl_drain_err", 128'h0);
    tick(); pop_chk(d0_err);

    // run=0 freezes state, removes bypass and suppresses stall
    do_reset();
    id_issue = 1'b1; id_we = 1'b1; id_waddr = 3'd3;
    tick();
    idle_inputs();
    run = 1'b0; rd_addr_a = 3'd3; rd_use_a = 1'b1;
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h7777;
    push("frz_stall", 128'h0); push("frz_nobyp", 128'h0);
    @(negedge clock); pop_chk(d0_stall); pop_chk(d0_rd_a);
    push("frz_reg", 128'h0);
    tick(); pop_chk(d0_flat[3*DATA_W +: DATA_W]);
    run = 1'b1; wb_we = 1'b0;
    push("frz_held_stall", 128'h1);
    @(negedge clock); pop_chk(d0_stall);
    tick();
    idle_inputs();
    tick();
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h3333;
    push("frz_wb_err", 128'h0);
    tick(); pop_chk(d0_err);
    idle_inputs();

    // Unexpected WB sets a sticky error; the write still lands
    do_reset();
    wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    push("mm_err", 128'h1); push("mm_write", 128'hBEEF);
    tick();
    pop_chk(d0_err); pop_chk(d0_flat[3*DATA_W +: DATA_W]);
    idle_inputs();
    repeat (10) begin
      push("mm_sticky", 128'h1);
      tick();
      pop_chk(d0_err);
    end
    reset = 1'b0;
    push("mm_cleared", 128'h0);
    tick(); pop_chk(d0_err);
    reset = 1'b1;

    // Hardwired r0: no hazard, reads 0, WB ignored without error
    do_reset();
    id_issue = 1'b1; id_we = 1'b1; id_waddr = 3'd0;
    tick();
    idle_inputs();
    rd_addr_a = 3'd0; rd_use_a = 1'b1;
    wb_we = 1'b1; wb_addr = 3'd0; wb_data = 16'h5555;
    push("z_stall", 128'h0); push("z_rdata", 128'h0);
    push("nz_stall", 128'h1); push("nz_byp", 128'h5555);
    @(negedge clock);
    pop_chk(d1_stall); pop_chk(d1_rd_a); pop_chk(d0_stall); pop_chk(d0_rd_a);
    push("z_err", 128'h0); push("z_reg0", 128'h0); push("nz_reg0", 128'h5555);
    tick();
    pop_chk(d1_err); pop_chk(d1_flat[0 +: DATA_W]); pop_chk(d0_flat[0 +: DATA_W]);
    idle_inputs();

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gr_file_sb.md
Name: gr_file_sb

Overview:
- Parametrised general-register file with an integrated destination scoreboard for the 5-stage pipelined CPU.
- Replaces the fixed 8x16 register array and its unguarded read path.
- Provides three bypassed read ports for ID (A, B, store data), one WB write port, and a RAW-hazard stall signal driven by a shift register of in-flight destinations.
- Supports flush of squashed destinations on taken jumps and a sticky consistency-error flag.

Parameters:
- DATA_W, 16, register width in bits.
- NREG, 8, number of general registers (power of 2, 2..32).
- AW, $clog2(NREG), register address width (derived; do not override).
- PIPE, 3, in-flight slots between ID issue and WB (EX, MEM, WB).
- FLUSH_N, 2, youngest slots invalidated by flush (1..PIPE-1).
- ZERO_R0, 0, when 1 register 0 reads as 0, ignores writes, and never raises a hazard.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  pipeline advance enable (CPU execute state); 0 freezes all state.
- rd_addr_a/b/c  in  AW each  ID read addresses.
- rd_use_a/b/c  in  1 each  port address is a real source operand.
- rd_data_a/b/c  out  DATA_W each  read data, combinational.
- id_issue  in  1  ID presents an instruction this cycle.
- id_we  in  1  issuing instruction writes a register.
- id_waddr  in  AW  issuing instruction's destination.
- flush  in  1  taken jump; squash the youngest FLUSH_N slots.
- wb_we  in  1  WB write strobe.
- wb_addr  in  AW  WB destination.
- wb_data  in  DATA_W  WB data.
- stall  out  1  RAW hazard; ID must hold, combinational.
- gr_flat  out  NREG*DATA_W  all registers, reg i at [i*DATA_W +: DATA_W].
- sb_err  out  1  sticky scoreboard/WB mismatch flag, registered.

Behaviour:
- Reset, with reset=0 on a rising edge:
  - All registers clear to 0.
  - All slots become invalid.
  - sb_err clears to 0.
  - Consequently stall=0, and rd_data and gr_flat are all 0.
  - Reset wins over run, flush and wb_we.
- Reads:
  - rd_data_x = wb_data when wb_we & run & wb_addr==rd_addr_x (and not (ZERO_R0 & addr==0)).
  - Otherwise rd_data_x = gr[rd_addr_x].
  - When ZERO_R0=1 and addr==0, rd_data_x = 0.
- Write: on a clock edge with run=1 and wb_we=1, gr[wb_addr] <= wb_data. Suppressed for addr 0 when ZERO_R0=1.
- Slots: slot[k] = {valid, addr}, with k=0 youngest and k=PIPE-1 in WB.
- stall = run & OR over x in {a,b,c} and k in 0..PIPE-2 of (rd_use_x & slot[k].valid & slot[k].addr==rd_addr_x).
  - Slot PIPE-1 never stalls; it is covered by the bypass.
- Advance, on an edge with run=1:
  - slot[k] <= slot[k-1] for k>=1.
  - slot[0] <= {id_issue & id_we & ~stall & ~(ZERO_R0 & id_waddr==0), id_waddr}.
  - A stalled cycle therefore inserts a bubble.
- Flush, on an edge with run=1 and flush=1: after the shift, slots 0..FLUSH_N-1 are invalid, and the issuing destination is discarded.
- run=0: slots, registers and sb_err hold; stall=0; no bypass.
- Consistency check, each edge with run=1, before the shift:
  - If wb_we differs from slot[PIPE-1].valid, sb_err <= 1.
  - If both are 1 and wb_addr differs from slot[PIPE-1].addr, sb_err <= 1.
  - sb_err stays set until reset.
  - The write is still performed.
- Simultaneous events:
  - Issue to reg r while WB writes r: both take effect; the new slot[0] marks r pending.
  - Flush and stall in the same cycle: flush dominates; slot 0 is invalid either way.
- Latency: a write is visible via bypass in the same cycle and via the array from the next cycle. Issue-to-WB is PIPE edges.

Decomposition:
- define.v gains the default register count/width constants and the slot field layout (valid bit, addr field).
- One sub-module, gr_dest_pipe: the PIPE-deep slot shift register with flush, hazard compare, and consistency check.
- The array and bypass muxes stay in gr_file_sb.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wb_we=1, wb_addr=3, wb_data=16'hFFFF -> gr_flat=0, stall=0, sb_err=0.
- Bypass: slot chain carries r5 to slot 2; wb_we=1, wb_addr=5, wb_data=16'h1234, rd_addr_a=5, rd_use_a=1 -> rd_data_a=16'h1234 the same cycle, stall=0, gr[5]=16'h1234 after the edge.
- RAW stall:
  - Cycle 0: issue id_we=1, id_waddr=2.
  - Cycle 1: rd_addr_b=2, rd_use_b=1 -> stall=1 for 2 cycles, 0 in the 3rd cycle, when slot 2 holds r2.
  - Stalled cycles leave slot 0 invalid.
- Flush: issue writes to r1, then r4, then assert flush with an issue to r6 -> afterwards only the r1 entry remains valid (slot 2); wb for r1 gives sb_err=0.
- Mismatch: wb_we=1 with slot[2] invalid -> sb_err=1 next edge and sticky through 10 cycles until reset=0.
- ZERO_R0=1: issue write to r0, then read r0 with rd_use_a=1 -> stall=0, rd_data_a=0, wb to r0 ignored with no sb_err.
